// File: rtl/phy_urx_pkg.sv
// Shared definitions for the UART receive PHY: FSM encoding and
// microsecond sample points measured from the detected start edge.
package phy_urx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } urx_state_e;

  localparam logic [7:0] SmpStart = 8'd4;
  localparam logic [7:0] SmpD0    = 8'd13;
  localparam logic [7:0] SmpD1    = 8'd21;
  localparam logic [7:0] SmpD2    = 8'd30;
  localparam logic [7:0] SmpD3    = 8'd39;
  localparam logic [7:0] SmpD4    = 8'd47;
  localparam logic [7:0] SmpD5    = 8'd56;
  localparam logic [7:0] SmpD6    = 8'd65;
  localparam logic [7:0] SmpD7    = 8'd73;
  localparam logic [7:0] SmpPar   = 8'd82;
  localparam logic [7:0] SmpStop  = 8'd91;

  function automatic logic is_data_smp(input logic [7:0] n);
    return (n == SmpD0) || (n == SmpD1) || (n == SmpD2) || (n == SmpD3) ||
           (n == SmpD4) || (n == SmpD5) || (n == SmpD6) || (n == SmpD7);
  endfunction

endpackage

// File: rtl/phy_urx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector
// on the synchronized level.
module phy_urx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/phy_urx.sv
// UART receiver: 8 data bits, even parity, one stop bit, timed entirely by
// a 1 us tick counted from the start edge.
module phy_urx
  import phy_urx_pkg::*;
(
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       pluse_us,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_vld,
  output logic       rx_err_par,
  output logic       rx_err_frm
);

  logic       line, fall;
  urx_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_nxt;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] data_q, data_d;
  logic       vld_q, vld_d;
  logic       errp_q, errp_d;
  logic       errf_q, errf_d;

  phy_urx_sync u_sync (
    .clk_i   (clk_sys),
    .rst_i   (rst),
    .rx_i    (uart_rx),
    .level_o (line),
    .fall_o  (fall)
  );

  // Saturate at the last sample point so the counter can never wrap.
  assign cnt_nxt = (cnt_q >= SmpStop) ? SmpStop : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    errp_d  = errp_q;
    errf_d  = errf_q;
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          cnt_d   = 8'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (pluse_us) begin
          cnt_d = cnt_nxt;
          if (cnt_nxt == SmpStart) state_d = line ? StIdle : StData;
        end
      end
      StData: begin
        if (pluse_us) begin
          cnt_d = cnt_nxt;
          if (is_data_smp(cnt_nxt)) shift_d = {line, shift_q[7:1]};
          if (cnt_nxt == SmpD7) state_d = StParity;
        end
      end
      StParity: begin
        if (pluse_us) begin
          cnt_d = cnt_nxt;
          if (cnt_nxt == SmpPar) begin
            par_d   = line;
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (pluse_us) begin
          cnt_d = cnt_nxt;
          if (cnt_nxt == SmpStop) begin
            data_d  = shift_q;
            vld_d   = 1'b1;
            errp_d  = (^shift_q) ^ par_q;
            errf_d  = ~line;
            state_d = line ? StIdle : StBreak;
          end
        end
      end
      StBreak: begin
        if (line) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      errp_q  <= 1'b0;
      errf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      errp_q  <= errp_d;
      errf_q  <= errf_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_vld     = vld_q;
  assign rx_err_par = errp_q;
  assign rx_err_frm = errf_q;

endmodule

// File: doc/phy_urx.md
PHY_URX -- requirements
Module: phy_urx

Interface
REQ-001 clk_sys  input  1  system clock; all logic on its rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 pluse_us  input  1  one-clk_sys-wide tick every 1 us; sole bit-time base.
REQ-004 uart_rx  input  1  asynchronous serial line; idles high.
REQ-005 rx_data  output  8  last received byte; LSB received first.
REQ-006 rx_vld  output  1  one-clk_sys pulse per completed frame.
REQ-007 rx_err_par  output  1  parity error of the frame flagged by rx_vld.
REQ-008 rx_err_frm  output  1  stop-bit error of the frame flagged by rx_vld.

Function
REQ-009 Frame format: start(0), d0..d7, even parity bit (XOR of d7..d0), stop(1), about 8.7 us per bit; frames repeat no faster than once per 100 us.
REQ-010 uart_rx passes through a 2-flop synchronizer; a falling edge is detected on the synchronized signal.
REQ-011 States: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-012 IDLE: a falling edge clears cnt_us (8 bit) to 0 and enters START.
REQ-013 In every state except IDLE and BREAK, cnt_us increments by 1 on each pluse_us.
REQ-014 A sample is the synchronized line value on the pluse_us cycle that advances cnt_us to N.
REQ-015 Sample points (N): start 4; d0..d7 13, 21, 30, 39, 47, 56, 65, 73; parity 82; stop 91.
REQ-016 START at N=4: line high means a false start; return to IDLE with no output. Line low: enter DATA.
REQ-017 DATA shifts the samples into a shift register LSB-first; after the d7 sample, enter PARITY.
REQ-018 PARITY captures the parity sample; after capture, enter STOP.
REQ-019 STOP at N=91: on the next cycle, drive rx_data from the shift register, pulse rx_vld, and set rx_err_par = (XOR of data) XOR parity sample and rx_err_frm = ~stop sample.
REQ-020 After STOP: a high stop sample enters IDLE; a low stop sample enters BREAK.
REQ-021 BREAK waits for the synchronized line to read high, then enters IDLE; no falling edge is accepted while in BREAK.
REQ-022 Falling edges seen outside IDLE are ignored.
REQ-023 rx_data, rx_err_par and rx_err_frm hold their values until the next rx_vld; they update only on the rx_vld cycle.
REQ-024 Latency: rx_vld is asserted 1 clk_sys after the pluse_us cycle of the stop sample.
REQ-025 A pluse_us arriving on the same cycle as the falling-edge detect is not counted.
REQ-026 cnt_us never wraps; its maximum value is 91.

Reset
REQ-027 rst high on any clock edge: state IDLE, cnt_us 0, shift register 0, synchronizer flops 1, rx_data 8'h00, rx_vld 0, rx_err_par 0, rx_err_frm 0.
REQ-028 Reset mid-frame abandons the frame with no rx_vld; after reset the receiver waits for a fresh falling edge.

Structure
REQ-029 A shared package holds the state encoding and the sample-point constants (4, 13, 21, 30, 39, 47, 56, 65, 73, 82, 91).
REQ-030 One sub-module, phy_urx_sync: the 2-flop synchronizer plus falling-edge detector; outputs the synchronized level and a one-cycle fall pulse.
REQ-031 No other sub-modules; the datapath and FSM live in phy_urx.

Verification
REQ-032 Frame 0xA5 with parity 0 and stop 1 -> one rx_vld, rx_data=8'hA5, rx_err_par=0, rx_err_frm=0.
REQ-033 Frame 0x01 sent with parity 0 (wrong) -> rx_data=8'h01, rx_err_par=1, rx_err_frm=0.
REQ-034 Frame 0x3C with the stop bit held low for 30 us, then high -> rx_vld with rx_err_frm=1; a falling edge during the low period produces no frame; the next valid frame 0x55 is received correctly.
REQ-035 Low glitch of 2 us on an idle line -> no rx_vld, state back to IDLE; a following frame 0x7E is received correctly.
REQ-036 Frames 0x12 and 0x34 sent back-to-back at 100 us spacing -> two rx_vld pulses, data 8'h12 then 8'h34, no errors.
REQ-037 rst asserted at cnt_us=40 of a frame -> no rx_vld for that frame, all outputs at reset values, the next frame is received correctly.
